ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It sends command bytes to the keyboard, for example 0xED (set LEDs) or 0xFF (reset).
- It is the other direction of the existing receive-only keyboard slave.
- It drives the shared ps2_clk/ps2_data lines through open-drain enables, sequences inhibit, request-to-send, data, parity, stop and acknowledge, then reports done or error to the keyboard bus slave.

Parameters:
- CLK_FREQ, 50000000: frequency of clk in Hz.
- INHIBIT_US, 100: time the host holds ps2_clk low before request-to-send.
- TIMEOUT_US, 15000: maximum time for a whole transaction, from leaving IDLE to ack.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command byte offered.
- cmd_data  in  8  command byte.
- cmd_ready  out  1  high only in IDLE; a transfer is accepted when cmd_valid and cmd_ready are both high.
- ps2_clk_i  in  1  raw ps2_clk pin level.
- ps2_data_i  in  1  raw ps2_data pin level.
- ps2_clk_oe  out  1  1 = pull ps2_clk low, 0 = release.
- ps2_data_oe  out  1  1 = pull ps2_data low, 0 = release.
- busy  out  1  transaction in progress; the top level uses it to gate the keyboard receiver.
- done  out  1  one-cycle pulse: device acknowledged.
- err  out  1  one-cycle pulse: failure.
- err_code  out  2  cause of failure; 01 = nack, 10 = timeout; held until the next accept.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go low immediately, including both oe lines released; err_code = 00; state = IDLE.
  - A reset mid-transfer abandons the byte with no done or err pulse.
- Input conditioning: ps2_clk_i and ps2_data_i pass through a 2-FF synchroniser. fall = synced clk was 1 last cycle and is 0 now.
- Constants: INH = CLK_FREQ/1e6*INHIBIT_US cycles; TO = CLK_FREQ/1e6*TIMEOUT_US cycles. Counters are sized with $clog2.
- On accept: latch cmd_data into shift register sh[7:0]; par = ~^cmd_data (odd parity); bitcnt = 0; timeout counter = 0; busy = 1 from the next cycle.
- States:
  - IDLE: no lines driven; cmd_ready = 1; accept -> INHIBIT.
  - INHIBIT: clk_oe = 1 for exactly INH cycles. Then clk_oe = 0 and data_oe = 1 (start bit) in the same cycle -> RTS.
  - RTS: wait for fall. On fall, drive bit 0: data_oe = ~sh[0]; shift sh right; bitcnt = 1 -> DATA.
  - DATA: on each fall, bitcnt is incremented.
    - bitcnt 1..7 -> drive sh[0].
    - bitcnt 8 -> drive par.
    - bitcnt 9 -> data_oe = 0 (stop bit) -> ACK.
    - Data changes only on the cycle fall is detected.
  - ACK: on fall, sample synced data. 0 -> WAIT_IDLE; 1 -> err, err_code = 01 -> IDLE.
  - WAIT_IDLE: wait until synced clk = 1 and data = 1, then done pulse -> IDLE.
- Timeout: the counter runs in every state except IDLE. Reaching TO releases both lines, pulses err, sets err_code = 10 and returns to IDLE. The timeout takes priority over a fall in the same cycle.
- cmd_valid while busy is ignored; it is not queued.
- done and err are mutually exclusive and never asserted in the same cycle.
- busy deasserts in the cycle after the done or err pulse.
- fall during INHIBIT is ignored, because the host is driving the clock.

Optional Feature:
- Macro: PS2TX_RETRY_EN.
- When defined:
  - On nack or timeout, the same byte is resent automatically from INHIBIT, up to 2 retries.
  - err pulses only after the third failure.
  - A retry_cnt[1:0] output reports the retries used; it is valid with done/err.
  - The timeout counter restarts per attempt.
- When undefined: the first failure pulses err, there is no retry_cnt port, and behaviour is as above.

Decomposition:
- Shared package ps2_pkg:
  - state enum {IDLE, INHIBIT, RTS, DATA, ACK, WAIT_IDLE};
  - err_code localparams ERR_NONE = 2'b00, ERR_NACK = 2'b01, ERR_TIMEOUT = 2'b10;
  - PS2 frame constants (DATA_BITS = 8, frame length 11).
  - The keyboard receiver reuses this package.
- One natural sub-module: ps2_line_sync. It contains the 2-FF synchronisers for clk and data plus the fall detector, and is shareable with the receiver.

Test Plan (CLK_FREQ = 1000000, so INH = 100 and TO = 15000; device BFM clocks at 20-cycle half periods after seeing RTS):
- Send 0xED, BFM acks -> clk_oe high for exactly 100 cycles; then data bits on successive falls 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop released; done pulses once; err_code = 00; busy then low.
- Send 0x00, BFM acks -> parity bit driven as 1 (odd); done pulses once.
- Send 0xFF, BFM holds data high at the ack fall -> err pulses, err_code = 01, no done. With PS2TX_RETRY_EN: three full frames are observed, then err with retry_cnt = 2.
- Send 0xF4, BFM never clocks -> err at 15000 cycles after accept, err_code = 10, both oe = 0.
- Second cmd_valid asserted during DATA -> cmd_ready = 0; the byte is not transmitted; only the first byte's frame appears.
- Assert rst at bitcnt = 4 -> both oe drop asynchronously in the same cycle, no done or err; the next command after release transmits correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, error codes and frame constants.
// Used by the host transmitter and the keyboard receiver.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RTS,
      DATA,
      ACK,
      WAIT_IDLE
   } ps2_state_e;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_NACK    = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 11;

   // bitcnt values inside DATA that select parity and stop
   localparam logic [3:0] PAR_IDX  = 4'(DATA_BITS);
   localparam logic [3:0] STOP_IDX = 4'(FRAME_BITS - 2);

   function automatic logic odd_parity(input logic [DATA_BITS-1:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronisers for the PS/2 clock and data pins plus a
// falling-edge detector on the synchronised clock.
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic clk_i,
   input  logic data_i,
   output logic clk_s,
   output logic data_s,
   output logic fall
);

   logic [1:0] clk_ff;
   logic [1:0] data_ff;
   logic       clk_d;

   // idle bus level is high, so reset to 1 to avoid a false fall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_ff  <= 2'b11;
         data_ff <= 2'b11;
         clk_d   <= 1'b1;
      end else begin
         clk_ff  <= {clk_ff[0], clk_i};
         data_ff <= {data_ff[0], data_i};
         clk_d   <= clk_ff[1];
      end
   end

   assign clk_s  = clk_ff[1];
   assign data_s = data_ff[1];
   assign fall   = clk_d & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain line enables.
// Define PS2TX_RETRY_EN to resend a failed byte up to two more times.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int INHIBIT_US = 100,
   parameter int TIMEOUT_US = 15000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       err,
`ifdef PS2TX_RETRY_EN
   output logic [1:0] retry_cnt,
`endif
   output logic [1:0] err_code
);

   localparam int CYC_PER_US = CLK_FREQ / 1000000;
   localparam int INH        = CYC_PER_US * INHIBIT_US;
   localparam int TO         = CYC_PER_US * TIMEOUT_US;
   localparam int TW         = $clog2(TO + 1);

   localparam logic [TW-1:0] INH_LAST = TW'(INH - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TO - 1);

   ps2_state_e state, state_n;

   logic [DATA_BITS-1:0] sh, sh_n;
   logic                 par, par_n;
   logic [3:0]           bitcnt, bitcnt_n;
   logic [TW-1:0]        tcnt, tcnt_n;
   logic                 clk_oe_n, data_oe_n;
   logic                 done_n, err_n, busy_n;
   logic [1:0]           err_code_n;

   logic       clk_s, data_s, fall;
   logic       accept;
   logic       fail;
   logic       give_up;
   logic [1:0] fail_code;

`ifdef PS2TX_RETRY_EN
   logic [DATA_BITS-1:0] byte_q, byte_n;
   logic [1:0]           retry_n;
`endif

   ps2_line_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .clk_i  (ps2_clk_i),
      .data_i (ps2_data_i),
      .clk_s  (clk_s),
      .data_s (data_s),
      .fall   (fall)
   );

   assign cmd_ready = (state == IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;

`ifdef PS2TX_RETRY_EN
   assign give_up = (retry_cnt == 2'd2);
`else
   assign give_up = 1'b1;
`endif

   always_comb begin
      state_n    = state;
      sh_n       = sh;
      par_n      = par;
      bitcnt_n   = bitcnt;
      tcnt_n     = tcnt;
      clk_oe_n   = ps2_clk_oe;
      data_oe_n  = ps2_data_oe;
      done_n     = 1'b0;
      err_n      = 1'b0;
      err_code_n = err_code;
      fail       = 1'b0;
      fail_code  = ERR_NONE;
`ifdef PS2TX_RETRY_EN
      byte_n     = byte_q;
      retry_n    = retry_cnt;
`endif

      if (state != IDLE)
         tcnt_n = tcnt + TW'(1);

      unique case (state)
         IDLE: begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            if (accept) begin
               state_n    = INHIBIT;
               sh_n       = cmd_data;
               par_n      = odd_parity(cmd_data);
               bitcnt_n   = 4'd0;
               tcnt_n     = '0;
               clk_oe_n   = 1'b1;
               err_code_n = ERR_NONE;
`ifdef PS2TX_RETRY_EN
               byte_n     = cmd_data;
               retry_n    = 2'd0;
`endif
            end
         end
         INHIBIT: begin
            // release clock and present the start bit together
            if (tcnt == INH_LAST) begin
               clk_oe_n  = 1'b0;
               data_oe_n = 1'b1;
               state_n   = RTS;
            end
         end
         RTS: begin
            if (fall) begin
               data_oe_n = ~sh[0];
               sh_n      = {1'b0, sh[DATA_BITS-1:1]};
               bitcnt_n  = 4'd1;
               state_n   = DATA;
            end
         end
         DATA: begin
            if (fall) begin
               bitcnt_n = bitcnt + 4'd1;
               if (bitcnt == STOP_IDX) begin
                  data_oe_n = 1'b0;
                  state_n   = ACK;
               end else if (bitcnt == PAR_IDX) begin
                  data_oe_n = ~par;
               end else begin
                  data_oe_n = ~sh[0];
                  sh_n      = {1'b0, sh[DATA_BITS-1:1]};
               end
            end
         end
         ACK: begin
            if (fall) begin
               if (!data_s) begin
                  state_n = WAIT_IDLE;
               end else begin
                  fail      = 1'b1;
                  fail_code = ERR_NACK;
               end
            end
         end
         WAIT_IDLE: begin
            if (clk_s && data_s) begin
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      // timeout outranks anything the state logic decided this cycle
      if (state != IDLE && tcnt == TO_LAST) begin
         fail      = 1'b1;
         fail_code = ERR_TIMEOUT;
      end

      if (fail) begin
         done_n = 1'b0;
         if (give_up) begin
            state_n    = IDLE;
            clk_oe_n   = 1'b0;
            data_oe_n  = 1'b0;
            err_n      = 1'b1;
            err_code_n = fail_code;
         end
`ifdef PS2TX_RETRY_EN
         else begin
            retry_n   = retry_cnt + 2'd1;
            state_n   = INHIBIT;
            sh_n      = byte_q;
            bitcnt_n  = 4'd0;
            tcnt_n    = '0;
            clk_oe_n  = 1'b1;
            data_oe_n = 1'b0;
         end
`endif
      end

      busy_n = (state_n != IDLE) || done_n || err_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         sh          <= '0;
         par         <= 1'b0;
         bitcnt      <= 4'd0;
         tcnt        <= '0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         busy        <= 1'b0;
         err_code    <= ERR_NONE;
`ifdef PS2TX_RETRY_EN
         byte_q      <= '0;
         retry_cnt   <= 2'd0;
`endif
      end else begin
         state       <= state_n;
         sh          <= sh_n;
         par         <= par_n;
         bitcnt      <= bitcnt_n;
         tcnt        <= tcnt_n;
         ps2_clk_oe  <= clk_oe_n;
         ps2_data_oe <= data_oe_n;
         done        <= done_n;
         err         <= err_n;
         busy        <= busy_n;
         err_code    <= err_code_n;
`ifdef PS2TX_RETRY_EN
         byte_q      <= byte_n;
         retry_cnt   <= retry_n;
`endif
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a PS/2 device model.
// Honours PS2TX_RETRY_EN when the design is built with it.
module tb_ps2_host_tx;

   localparam int CLK_FREQ   = 1000000;
   localparam int INHIBIT_US = 100;
   localparam int TIMEOUT_US = 15000;
   localparam int INH        = CLK_FREQ / 1000000 * INHIBIT_US;
   localparam int TO         = CLK_FREQ / 1000000 * TIMEOUT_US;
   localparam int HALF       = 20;
`ifdef PS2TX_RETRY_EN
   localparam int ATTEMPTS   = 3;
`else
   localparam int ATTEMPTS   = 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_ready;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       busy, done, err;
   logic [1:0] err_code;
`ifdef PS2TX_RETRY_EN
   logic [1:0] retry_cnt;
`endif

   logic dev_clk = 1'b1;
   logic dev_data = 1'b1;
   logic pin_clk, pin_data;

   assign pin_clk  = dev_clk & ~ps2_clk_oe;
   assign pin_data = dev_data & ~ps2_data_oe;

   int n_checks = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int err_cnt = 0;

   ps2_host_tx #(
      .CLK_FREQ   (CLK_FREQ),
      .INHIBIT_US (INHIBIT_US),
      .TIMEOUT_US (TIMEOUT_US)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_data    (cmd_data),
      .cmd_ready   (cmd_ready),
      .ps2_clk_i   (pin_clk),
      .ps2_data_i  (pin_data),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .busy        (busy),
      .done        (done),
      .err         (err),
`ifdef PS2TX_RETRY_EN
      .retry_cnt   (retry_cnt),
`endif
      .err_code    (err_code)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (err === 1'b1) err_cnt++;
      if (done === 1'b1 || err === 1'b1) begin
         n_checks++;
         if (done === 1'b1 && err === 1'b1) begin
            n_fail++;
            $display("FAIL done_err_exclusive: both high at %0t", $time);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   // expected line bits: 8 data LSB first, odd parity, stop
   function automatic logic [9:0] frame_of(input logic [7:0] b);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      return {1'b1, (ones % 2 == 0), b};
   endfunction

   task automatic send_cmd(input logic [7:0] b);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_data  = b;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy !== 1'b0 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_busy_timeout: busy=%b expected 0", nm, busy);
      end
   endtask

   task automatic measure_inhibit(input string nm);
      int inh = 0;
      while (ps2_clk_oe === 1'b1 && inh < 1000) begin
         inh++;
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (inh !== INH) begin
         n_fail++;
         $display("FAIL %s_inhibit_len: got %0d expected %0d", nm, inh, INH);
      end
      n_checks++;
      if (ps2_data_oe !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_start_bit: data_oe=%b expected 1", nm, ps2_data_oe);
      end
   endtask

   // device side: wait for request-to-send, then clock nclk bits
   task automatic bfm_frame(input int nclk, input bit ack,
                            output logic [10:0] cap, output bit ok);
      int n = 0;
      cap = '1;
      ok  = 1'b1;
      while (!(pin_clk === 1'b1 && pin_data === 1'b0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         ok = 1'b0;
         return;
      end
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nclk; i++) begin
         if (i == 10 && ack) dev_data = 1'b0;
         repeat (5) @(negedge clk);
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         dev_clk = 1'b1;
         cap[i] = pin_data;
         repeat (HALF - 5) @(negedge clk);
      end
      dev_data = 1'b1;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #7;
      n_checks++;
      if ({cmd_ready, busy, done, err, ps2_clk_oe, ps2_data_oe, err_code}
          !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected 00000000",
                  {cmd_ready, busy, done, err, ps2_clk_oe, ps2_data_oe,
                   err_code});
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: got %b expected 1", cmd_ready);
      end
   endtask

   task automatic test_send(input logic [7:0] b, input string nm);
      logic [10:0] cap;
      bit          ok;
      int          d0 = done_cnt;
      int          e0 = err_cnt;
      send_cmd(b);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_busy_after_accept: got %b expected 1", nm, busy);
      end
      measure_inhibit(nm);
      bfm_frame(11, 1'b1, cap, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s_rts: no request-to-send seen", nm);
      end
      n_checks++;
      if (cap[9:0] !== frame_of(b)) begin
         n_fail++;
         $display("FAIL %s_frame: got %b expected %b", nm, cap[9:0],
                  frame_of(b));
      end
      wait_idle(nm);
      n_checks++;
      if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
         n_fail++;
         $display("FAIL %s_done_count: done=%0d err=%0d expected 1/0", nm,
                  done_cnt - d0, err_cnt - e0);
      end
      n_checks++;
      if (err_code !== 2'b00) begin
         n_fail++;
         $display("FAIL %s_err_code: got %b expected 00", nm, err_code);
      end
   endtask

   task automatic test_nack();
      logic [10:0] cap;
      bit          ok;
      int          d0 = done_cnt;
      int          e0 = err_cnt;
      send_cmd(8'hFF);
      for (int a = 0; a < ATTEMPTS; a++) begin
         bfm_frame(11, 1'b0, cap, ok);
         n_checks++;
         if (!ok || cap[9:0] !== frame_of(8'hFF)) begin
            n_fail++;
            $display("FAIL nack_frame%0d: ok=%0d got %b expected %b", a, ok,
                     cap[9:0], frame_of(8'hFF));
         end
      end
      wait_idle("nack");
      n_checks++;
      if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
         n_fail++;
         $display("FAIL nack_pulses: err=%0d done=%0d expected 1/0",
                  err_cnt - e0, done_cnt - d0);
      end
`ifdef PS2TX_RETRY_EN
      n_checks++;
      if (retry_cnt !== 2'd2) begin
         n_fail++;
         $display("FAIL nack_retry_cnt: got %0d expected 2", retry_cnt);
      end
`endif
      repeat (50) @(negedge clk);
      n_checks++;
      if (err_code !== 2'b01) begin
         n_fail++;
         $display("FAIL nack_err_code_held: got %b expected 01", err_code);
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      int d0 = done_cnt;
      send_cmd(8'hF4);
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (err !== 1'b1 && n < TO * ATTEMPTS + 100);
      n_checks++;
      if (n !== TO * ATTEMPTS) begin
         n_fail++;
         $display("FAIL timeout_latency: got %0d expected %0d", n,
                  TO * ATTEMPTS);
      end
      n_checks++;
      if ({ps2_clk_oe, ps2_data_oe, err_code} !== 4'b0010) begin
         n_fail++;
         $display("FAIL timeout_state: oe=%b%b code=%b expected 00 10",
                  ps2_clk_oe, ps2_data_oe, err_code);
      end
      wait_idle("timeout");
      n_checks++;
      if (done_cnt !== d0) begin
         n_fail++;
         $display("FAIL timeout_no_done: got %0d expected %0d", done_cnt, d0);
      end
   endtask

   task automatic test_busy_ignore();
      logic [10:0] cap;
      bit          ok;
      bit          saw_ready = 1'b0;
      bit          saw_clk = 1'b0;
      logic [7:0]  a = 8'($urandom);
      int          d0 = done_cnt;
      send_cmd(a);
      fork
         bfm_frame(11, 1'b1, cap, ok);
         begin
            repeat (300) @(negedge clk);
            cmd_valid = 1'b1;
            cmd_data  = ~a;
            repeat (20) begin
               @(posedge clk);
               #1;
               if (cmd_ready !== 1'b0) saw_ready = 1'b1;
            end
            cmd_valid = 1'b0;
         end
      join
      n_checks++;
      if (saw_ready) begin
         n_fail++;
         $display("FAIL busy_ready: got 1 expected 0 during DATA");
      end
      n_checks++;
      if (!ok || cap[9:0] !== frame_of(a)) begin
         n_fail++;
         $display("FAIL busy_frame: got %b expected %b", cap[9:0],
                  frame_of(a));
      end
      wait_idle("busy");
      repeat (300) begin
         @(negedge clk);
         if (ps2_clk_oe !== 1'b0 || busy !== 1'b0) saw_clk = 1'b1;
      end
      n_checks++;
      if (saw_clk || done_cnt - d0 !== 1) begin
         n_fail++;
         $display("FAIL busy_not_queued: restart=%0d done=%0d expected 0/1",
                  saw_clk, done_cnt - d0);
      end
   endtask

   task automatic test_reset_mid();
      logic [10:0] cap;
      bit          ok;
      logic [7:0]  a = 8'($urandom) & 8'hF7;
      int          d0, e0;
      send_cmd(a);
      measure_inhibit("rstmid");
      bfm_frame(4, 1'b1, cap, ok);
      d0 = done_cnt;
      e0 = err_cnt;
      #3;
      n_checks++;
      if (ps2_data_oe !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_bit3_driven: got %b expected 1", ps2_data_oe);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL rstmid_async: got %b expected 000",
                  {ps2_clk_oe, ps2_data_oe, busy});
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      n_checks++;
      if (done_cnt !== d0 || err_cnt !== e0) begin
         n_fail++;
         $display("FAIL rstmid_no_pulse: done=%0d err=%0d expected %0d/%0d",
                  done_cnt, err_cnt, d0, e0);
      end
      test_send(8'($urandom), "after_rst");
   endtask

   initial begin
      test_reset();
      test_send(8'hED, "send_ed");
      test_send(8'h00, "send_00");
      for (int i = 0; i < 4; i++) test_send(8'($urandom), "send_rand");
      test_nack();
      test_send(8'h5A, "after_nack");
      test_timeout();
      test_busy_ignore();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
